// File: rtl/mic_pkg.sv
// Shared widths, request word layout and FSM state encoding for the memory interface arbiter.
package mic_pkg;

  localparam int NREQS  = 3;
  localparam int AWIDTH = 8;
  localparam int MWIDTH = 32;
  localparam int RWIDTH = MWIDTH + AWIDTH + 2;
  localparam int IDW    = (NREQS > 1) ? $clog2(NREQS) : 1;

  typedef struct packed {
    logic [MWIDTH-1:0] data;
    logic [AWIDTH-1:0] addr;
    logic              rd;
    logic              wr;
  } mic_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } mic_state_t;

endpackage

// File: rtl/mic_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo NREQS.
module mic_rr_pick #(
  parameter int NREQS = mic_pkg::NREQS,
  parameter int IW    = mic_pkg::IDW
) (
  input  logic [NREQS-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [NREQS-1:0] gnt,
  output logic [IW-1:0]    idx
);
  import mic_pkg::*;

  always_comb begin
    logic          found;
    int            c;
    logic [IW-1:0] cw;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    cw    = '0;
    for (int i = 0; i < NREQS; i++) begin
      c = int'(ptr) + i;
      if (c >= NREQS) c = c - NREQS;
      cw = IW'(c);
      if (!found && req[cw]) begin
        found   = 1'b1;
        gnt[cw] = 1'b1;
        idx     = cw;
      end
    end
  end

endmodule

// File: rtl/mic_arbiter.sv
// Round-robin arbiter from NREQS show-ahead request FIFOs onto one memory port.
// Optional illegal-opcode counter enabled by defining MIC_ARB_ERR_CNT_EN.
module mic_arbiter #(
  parameter int NREQS  = mic_pkg::NREQS,
  parameter int AWIDTH = mic_pkg::AWIDTH,
  parameter int MWIDTH = mic_pkg::MWIDTH,
  localparam int IW    = (NREQS > 1) ? $clog2(NREQS) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NREQS-1:0]           fifo_empty,
  input  logic [MWIDTH+AWIDTH+1:0]   fifo_rdata [NREQS],
  output logic [NREQS-1:0]           fifo_pop,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [AWIDTH-1:0]          mem_addr,
  output logic [MWIDTH-1:0]          mem_wdata,
  input  logic [MWIDTH-1:0]          mem_rdata,
  output logic                       rsp_valid,
  output logic [IW-1:0]              rsp_id,
  output logic [MWIDTH-1:0]          rsp_data,
  output logic                       busy,
  output logic [7:0]                 err_count
);
  import mic_pkg::*;

  localparam int RW = MWIDTH + AWIDTH + 2;

  mic_state_t        state;
  logic [NREQS-1:0]  req;
  logic [NREQS-1:0]  pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     gnt_idx;
  logic              any_req;
  logic [RW-1:0]     head;
  logic              head_wr;
  logic              head_rd;
  logic [AWIDTH-1:0] head_addr;
  logic [MWIDTH-1:0] head_data;
  logic              op_rd;
  logic              op_wr;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
    return (p == IW'(NREQS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req       = ~fifo_empty;
  assign any_req   = |req;
  assign head      = fifo_rdata[pick_idx];
  assign head_wr   = head[0];
  assign head_rd   = head[1];
  assign head_addr = head[AWIDTH+1:2];
  assign head_data = head[RW-1:AWIDTH+2];

  mic_rr_pick #(.NREQS(NREQS), .IW(IW)) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Pop must coincide with the IDLE cycle that latches the show-ahead head word.
  assign fifo_pop = (state == IDLE && any_req) ? pick_gnt : '0;
  assign busy     = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      op_rd     <= 1'b0;
      op_wr     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        // grant and latch head word; memory strobes appear in ISSUE
        IDLE: begin
          if (any_req) begin
            gnt_idx   <= pick_idx;
            op_rd     <= head_rd;
            op_wr     <= head_wr;
            mem_en    <= head_rd ^ head_wr;
            mem_we    <= head_wr & ~head_rd;
            mem_addr  <= head_addr;
            mem_wdata <= head_data;
            state     <= ISSUE;
          end
        end
        // memory access cycle; illegal opcodes fall straight back to IDLE
        ISSUE: begin
          rr_ptr <= next_ptr(gnt_idx);
          state  <= (op_rd && !op_wr) ? RDWAIT : IDLE;
        end
        // read data arrives this cycle
        RDWAIT: begin
          rsp_data  <= mem_rdata;
          rsp_id    <= gnt_idx;
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MIC_ARB_ERR_CNT_EN
  logic [7:0] err_q;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 8'h00;
    end else if (state == ISSUE && (op_rd == op_wr)) begin
      err_q <= sat_inc8(err_q);
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: doc/mic_arbiter.md
MIC_ARBITER -- requirements
Module: mic_arbiter

Interface
REQ-001 Parameter NREQS, default mic_pkg::NREQS, number of requester FIFOs.
REQ-002 Parameter AWIDTH, default mic_pkg::AWIDTH, memory address width.
REQ-003 Parameter MWIDTH, default mic_pkg::MWIDTH, memory data width.
REQ-004 clock  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 fifo_empty  in  NREQS  per-requester FIFO empty flag.
REQ-007 fifo_rdata  in  NREQS x RWIDTH (unpacked)  show-ahead head word, format {data, addr, rd, wr}; bit0=wr, bit1=rd.
REQ-008 fifo_pop  out  NREQS  one-hot pop strobe, one cycle.
REQ-009 mem_en  out  1  memory access strobe.
REQ-010 mem_we  out  1  write enable, qualified by mem_en.
REQ-011 mem_addr  out  AWIDTH  memory address.
REQ-012 mem_wdata  out  MWIDTH  write data.
REQ-013 mem_rdata  in  MWIDTH  read data, valid the cycle after mem_en && !mem_we.
REQ-014 rsp_valid  out  1  one-cycle read-response strobe to the output register.
REQ-015 rsp_id  out  IDW (mic_pkg)  requester index of the response.
REQ-016 rsp_data  out  MWIDTH  read data.
REQ-017 busy  out  1  high whenever state != IDLE.
REQ-018 err_count  out  8  illegal-opcode counter (see Configuration).

Function
REQ-019 FSM states IDLE, ISSUE, RDWAIT; IDLE is the reset state.
REQ-020 IDLE: if any fifo_empty bit is low, grant the first non-empty requester at or after rr_ptr (modulo NREQS), pulse its fifo_pop, latch its head word, go to ISSUE; otherwise stay in IDLE with all outputs deasserted.
REQ-021 ISSUE (one cycle): mem_en=1, mem_we=wr, mem_addr/mem_wdata from the latched word; rr_ptr <= (grant+1) mod NREQS; next state is RDWAIT for a read, IDLE for a write.
REQ-022 RDWAIT (one cycle): register mem_rdata into rsp_data and the grant into rsp_id; rsp_valid is high for exactly the following cycle; next state IDLE.
REQ-023 Read latency: pop at cycle T, mem_en at T+1, rsp_valid at T+3; write occupancy 2 cycles, read occupancy 3 cycles.
REQ-024 Illegal opcode (rd==wr): the word is popped, no mem_en is asserted, rr_ptr advances, and the FSM returns to IDLE from ISSUE.
REQ-025 fifo_pop never asserts to an empty FIFO, and at most one bit is set per cycle.
REQ-026 rsp_data holds its last value when rsp_valid is low.
REQ-027 A requester becoming non-empty while the FSM is busy is considered only in the next IDLE cycle; there is no preemption.
REQ-028 rr_ptr wraps from NREQS-1 to 0.

Reset
REQ-029 Reset forces state=IDLE, rr_ptr=0, fifo_pop=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_id=0, rsp_data=0, err_count=0, busy=0.
REQ-030 Reset mid-transaction aborts it: no rsp_valid is issued for an in-flight read, and the popped word is dropped.

Configuration
REQ-031 Macro MIC_ARB_ERR_CNT_EN defined: err_count increments on each illegal opcode and saturates at 8'hFF.
REQ-032 Macro MIC_ARB_ERR_CNT_EN undefined: err_count is tied to 0 and no counter logic is present.

Structure
REQ-033 mic_pkg holds NREQS, AWIDTH, MWIDTH, RWIDTH (=MWIDTH+AWIDTH+2), IDW (=$clog2(NREQS), minimum 1), the request struct typedef, and the FSM state enum.
REQ-034 The rotate-and-priority-select logic is one sub-module, mic_rr_pick (inputs: request vector, pointer; output: one-hot grant and index).

Verification
REQ-035 Reset, all FIFOs empty for 20 cycles -> no fifo_pop, no mem_en, busy=0.
REQ-036 Req0 write {32'hA5A5A5A5, 8'h10, rd=0, wr=1} -> fifo_pop=3'b001 at T, mem_en=1, mem_we=1, addr 8'h10 at T+1, no rsp_valid.
REQ-037 Req1 read of addr 8'h20 holding 32'h55AA55AA -> rsp_valid at T+3 with rsp_id=1, rsp_data=32'h55AA55AA.
REQ-038 NREQS=3, all FIFOs holding 2 writes, rr_ptr=0 -> grant order 0,1,2,0,1,2.
REQ-039 Opcode rd=1, wr=1 from req2 -> popped, no mem_en, err_count=1 with macro defined, 0 without.
REQ-040 Reset asserted during RDWAIT -> no rsp_valid, state IDLE, rr_ptr=0 on the next cycle.
